demux1to2_16bit_buf: RTL
========================

// Module: demux1to2_16bit_buf
//
// PURPOSE
//  Steers a 16-bit data stream to one of two buffered output channels; the counterpart of the
//  16-bit 2-to-1 mux (split rather than merge).
//  Sits between the datapath result bus and two consumers (register-file write port / memory write
//  port) so each consumer can stall independently without losing words.
//  Each channel owns a small FIFO with a valid/ready handshake.
//
// PARAMETERS
//  WIDTH   16  data width of in_data / outN_data
//  DEPTH    2  entries per output FIFO (power of 2, >= 2)
//  CW       8  width of optional transfer counters
//
// PORTS
//  clk        in   1      single clock, rising edge
//  reset_n    in   1      asynchronous, active-low reset
//  select     in   1      0 -> channel 0, 1 -> channel 1; qualified by in_valid
//  in_valid   in   1      producer has a word
//  in_ready   out  1      selected channel can accept
//  in_data    in   WIDTH  word to route
//  out0_valid out  1      channel 0 head valid
//  out0_ready in   1      channel 0 consumer accepts
//  out0_data  out  WIDTH  channel 0 head word
//  out1_valid out  1      channel 1 head valid
//  out1_ready in   1      channel 1 consumer accepts
//  out1_data  out  WIDTH  channel 1 head word
//  cnt0, cnt1 out  CW     words delivered per channel (DEMUX_COUNT_EN only)
//
// BEHAVIOUR
//  - Reset (reset_n low, any time, async): both FIFOs empty, outN_valid=0, outN_data=0,
//    pointers=0, cnt0/cnt1=0. Words in flight at reset are discarded.
//  - in_ready = ~full[select]; combinational from select and FIFO state only, never from in_valid.
//  - Push: in_valid & in_ready at rising edge -> in_data written to FIFO[select].
//    The other FIFO is untouched.
//  - Pop: outN_valid & outN_ready at rising edge -> FIFO N head removed.
//  - Latency: word pushed at edge k appears on outN_data with outN_valid=1 after edge k
//    (1 cycle); no combinational in->out path.
//  - outN_valid = ~empty[N]; outN_data = head entry (first-word-fall-through),
//    stable while valid & ~ready.
//  - Per-channel order preserved. No ordering guarantee across channels.
//  - Occupancy counter per FIFO, 0..DEPTH; full = (occ==DEPTH), empty = (occ==0).
//    Pointers wrap modulo DEPTH.
//  - Simultaneous push+pop, same channel, not full: occupancy unchanged, both happen.
//  - Full channel with pop in the same cycle: in_ready still 0 (no pass-through on full);
//    the push waits one cycle.
//  - Empty channel with push: pop impossible that cycle (valid=0); the word is visible next cycle.
//  - Push to channel A while channel B is full: allowed; B's stall never blocks A.
//  - select may change every cycle; the producer must hold in_data/select while
//    in_valid & ~in_ready.
//
// CONFIGURATION
//  DEMUX_COUNT_EN defined:
//   - cnt0/cnt1 are present.
//   - cntN increments on each channel N pop, wraps 2^CW-1 -> 0, and resets to 0.
//  DEMUX_COUNT_EN undefined:
//   - cnt0/cnt1 ports and logic are absent.
//   - All other behaviour is identical.
//
// TESTING
//  1 reset: reset_n=0 -> in_ready=1, out0_valid=out1_valid=0, data=16'h0000.
//  2 route: sel=0 push 16'h1234, sel=1 push 16'hABCD, both ready=1
//    -> out0 16'h1234 and out1 16'hABCD, each one cycle after its push.
//  3 fill: out0_ready=0, push 16'h0001, 16'h0002 on ch0
//    -> in_ready=0 for sel=0 and 1 for sel=1; push 16'h0003 to ch1 succeeds.
//    Release ready -> ch0 pops 0001, 0002 in order.
//  4 full+pop: ch0 full, out0_ready=1 with in_valid sel=0 16'h0004
//    -> not accepted that cycle, accepted next; no loss, no duplicate.
//  5 async reset mid-stream: reset_n low between edges with both FIFOs holding data
//    -> valid drops immediately; after release both channels are empty.
//  6 DEMUX_COUNT_EN: 257 pops on ch1 with CW=8 -> cnt1=1, cnt0=0.

Source files
------------

// File: rtl/demux1to2_16bit_buf_if.sv
// ============================================================================
// Module   : demux1to2_16bit_buf_if
// Purpose  : Producer-side and consumer-side handshake bundle for the 1-to-2 demux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface demux1to2_16bit_buf_if #(
    parameter int WIDTH = 16
);
    logic             select;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;

    modport master (
        output select, in_valid, in_data, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out1_valid, out1_data
    );

    modport slave (
        input  select, in_valid, in_data, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out1_valid, out1_data
    );
endinterface

`default_nettype wire

// File: rtl/demux1to2_16bit_buf.sv
// ============================================================================
// Module   : demux1to2_16bit_buf
// Purpose  : Routes a 16-bit valid/ready stream into one of two FWFT FIFOs.
//            Define DEMUX_COUNT_EN to add per-channel delivered-word counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux1to2_16bit_buf #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    parameter int CW    = 8
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    demux1to2_16bit_buf_if.slave   bus
`ifdef DEMUX_COUNT_EN
    ,
    output      logic [CW-1:0]     cnt0,
    output      logic [CW-1:0]     cnt1
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);

    logic [1:0]            w_full;
    logic [1:0]            w_empty;
    logic [1:0]            w_push;
    logic [1:0]            w_pop;
    logic [1:0]            w_out_ready;
    logic [1:0][WIDTH-1:0] w_out_data;

    // Readiness depends only on the addressed FIFO, never on in_valid.
    assign bus.in_ready   = ~w_full[bus.select];
    assign w_out_ready    = {bus.out1_ready, bus.out0_ready};
    assign bus.out0_valid = ~w_empty[0];
    assign bus.out1_valid = ~w_empty[1];
    assign bus.out0_data  = w_out_data[0];
    assign bus.out1_data  = w_out_data[1];

    for (genvar n = 0; n < 2; n++) begin : g_ch
        logic [WIDTH-1:0] mem_q [DEPTH];
        logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
        logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
        logic [OW-1:0]    occ_q, occ_d;

        assign w_full[n]  = (occ_q == OW'(DEPTH));
        assign w_empty[n] = (occ_q == '0);
        assign w_push[n]  = bus.in_valid & ~w_full[n] & (bus.select == 1'(n));
        assign w_pop[n]   = ~w_empty[n] & w_out_ready[n];

        // Empty channels present zero so the data bus never shows stale words.
        assign w_out_data[n] = w_empty[n] ? '0 : mem_q[rd_ptr_q];

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            occ_d    = occ_q;
            if (w_push[n]) wr_ptr_d = wr_ptr_q + AW'(1);
            if (w_pop[n])  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({w_push[n], w_pop[n]})
                2'b10:   occ_d = occ_q + OW'(1);
                2'b01:   occ_d = occ_q - OW'(1);
                default: occ_d = occ_q;
            endcase
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                occ_q    <= '0;
            end else begin
                if (w_push[n]) mem_q[wr_ptr_q] <= bus.in_data;
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                occ_q    <= occ_d;
            end
        end

`ifdef DEMUX_COUNT_EN
        logic [CW-1:0] cnt_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)      cnt_q <= '0;
            else if (w_pop[n]) cnt_q <= cnt_q + CW'(1);
        end
`endif
    end

`ifdef DEMUX_COUNT_EN
    assign cnt0 = g_ch[0].cnt_q;
    assign cnt1 = g_ch[1].cnt_q;
`endif

endmodule

`default_nettype wire
